// File: rtl/mod_test_pkg.sv
// Shared definitions for the DE2 bring-up top: display glyphs, ASCII debug
// characters and the helpers that map a hex nibble onto each of them.
package mod_test_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_x   = 8'h78;
    localparam logic [7:0] ASCII_A   = 8'h41;

    // Active-low segments, index 0 = a ... 6 = g.
    function automatic logic [0:6] hex_to_seg(input logic [3:0] digit);
        logic [0:6] seg;
        case (digit)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Uppercase hex digit character.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] digit);
        if (digit < 4'd10)
            return ASCII_0 + {4'd0, digit};
        else
            return ASCII_A + {4'd0, digit} - 8'd10;
    endfunction

endpackage

// File: rtl/mod_test_hex7seg.sv
// Single 7-segment decoder.
//   digit : 4-bit hex value
//   seg   : active-low segments, index 0 = a ... 6 = g
module hex7seg
    import mod_test_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/mod_test.sv
// DE2 bring-up top. Captures SW[15:0] on each press of KEY[1] and shows the
// live and captured words on the 7-segment displays, LEDs and two ASCII
// debug lines.
//   CLOCK_50          : system clock
//   KEY[0]            : asynchronous active-low reset
//   KEY[1]            : active-low load button (not debounced)
//   SW[15:0]          : data word, SW[17:16] mirrored on LEDR only
//   HEX7..HEX4        : live SW digits, HEX3..HEX0 : captured digits
//   LEDR              : live SW mirror
//   LEDG[7:0]         : load counter, LEDG[8] : captured == live
//   w_d0x*, w_d1x*    : "0x" + four hex characters, live / captured
//   UART_TXD          : held idle, GPIO_0/1 : released (high-Z)
module mod_test
    import mod_test_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        CLOCK_27,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [0:6]  HEX0,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX3,
    output logic [0:6]  HEX4,
    output logic [0:6]  HEX5,
    output logic [0:6]  HEX6,
    output logic [0:6]  HEX7,
    output logic [8:0]  LEDG,
    output logic [17:0] LEDR,
    output logic        UART_TXD,
    input  logic        UART_RXD,
    output logic [7:0]  w_d0x0,
    output logic [7:0]  w_d0x1,
    output logic [7:0]  w_d0x2,
    output logic [7:0]  w_d0x3,
    output logic [7:0]  w_d0x4,
    output logic [7:0]  w_d0x5,
    output logic [7:0]  w_d1x0,
    output logic [7:0]  w_d1x1,
    output logic [7:0]  w_d1x2,
    output logic [7:0]  w_d1x3,
    output logic [7:0]  w_d1x4,
    output logic [7:0]  w_d1x5,
    inout  wire  [35:0] GPIO_0,
    inout  wire  [35:0] GPIO_1
);

    logic clk;
    logic rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, CLOCK_27, KEY[3:2], UART_RXD};

    // KEY[1] synchronizer (s1, s2) plus a history flop (s3). All three
    // reset to 1 so that a key held through reset still yields one load.
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [15:0] cap_q, cap_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        load;

    // Falling edge of the synchronized button.
    assign load = s3_q & ~s2_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        s1_d  = KEY[1];
        s2_d  = s1_q;
        s3_d  = s2_q;
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (load) begin
            cap_d = SW[15:0];
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of the others (the synchronizer chain relies on it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            s3_q  <= 1'b1;
            cap_q <= 16'h0000;
            cnt_q <= 8'h00;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
        end
    end

    // Displays: live word on the left bank, captured word on the right.
    hex7seg u_hex7 (.digit(SW[15:12]),    .seg(HEX7));
    hex7seg u_hex6 (.digit(SW[11:8]),     .seg(HEX6));
    hex7seg u_hex5 (.digit(SW[7:4]),      .seg(HEX5));
    hex7seg u_hex4 (.digit(SW[3:0]),      .seg(HEX4));
    hex7seg u_hex3 (.digit(cap_q[15:12]), .seg(HEX3));
    hex7seg u_hex2 (.digit(cap_q[11:8]),  .seg(HEX2));
    hex7seg u_hex1 (.digit(cap_q[7:4]),   .seg(HEX1));
    hex7seg u_hex0 (.digit(cap_q[3:0]),   .seg(HEX0));

    assign LEDR = SW;
    assign LEDG = {(cap_q == SW[15:0]), cnt_q};

    assign w_d0x0 = ASCII_0;
    assign w_d0x1 = ASCII_x;
    assign w_d0x2 = hex_to_ascii(SW[15:12]);
    assign w_d0x3 = hex_to_ascii(SW[11:8]);
    assign w_d0x4 = hex_to_ascii(SW[7:4]);
    assign w_d0x5 = hex_to_ascii(SW[3:0]);

    assign w_d1x0 = ASCII_0;
    assign w_d1x1 = ASCII_x;
    assign w_d1x2 = hex_to_ascii(cap_q[15:12]);
    assign w_d1x3 = hex_to_ascii(cap_q[11:8]);
    assign w_d1x4 = hex_to_ascii(cap_q[7:4]);
    assign w_d1x5 = hex_to_ascii(cap_q[3:0]);

    assign UART_TXD = 1'b1;
    assign GPIO_0   = {36{1'bz}};
    assign GPIO_1   = {36{1'bz}};

endmodule

// File: tb/tb_mod_test.sv
// Self-checking bench for mod_test: a small behavioural model (glyph table,
// character string, captured word and press count) predicts every visible
// output, and each scenario task compares the DUT against it.
module tb_mod_test;

    logic        clk_50;
    logic        clk_27;
    logic        rst_n;
    logic        key1;
    logic [17:0] sw;
    logic        uart_rxd;

    logic [0:6]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [8:0]  ledg;
    logic [17:0] ledr;
    logic        uart_txd;
    logic [7:0]  d0x0, d0x1, d0x2, d0x3, d0x4, d0x5;
    logic [7:0]  d1x0, d1x1, d1x2, d1x3, d1x4, d1x5;
    wire  [35:0] gpio_0;
    wire  [35:0] gpio_1;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] m_cap;
    int          m_cnt;

    mod_test dut (
        .CLOCK_50(clk_50), .CLOCK_27(clk_27),
        .KEY({2'b11, key1, rst_n}), .SW(sw),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
        .HEX4(hex4), .HEX5(hex5), .HEX6(hex6), .HEX7(hex7),
        .LEDG(ledg), .LEDR(ledr),
        .UART_TXD(uart_txd), .UART_RXD(uart_rxd),
        .w_d0x0(d0x0), .w_d0x1(d0x1), .w_d0x2(d0x2),
        .w_d0x3(d0x3), .w_d0x4(d0x4), .w_d0x5(d0x5),
        .w_d1x0(d1x0), .w_d1x1(d1x1), .w_d1x2(d1x2),
        .w_d1x3(d1x3), .w_d1x4(d1x4), .w_d1x5(d1x5),
        .GPIO_0(gpio_0), .GPIO_1(gpio_1)
    );

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    initial begin
        clk_27 = 1'b0;
        forever #18 clk_27 = ~clk_27;
    end

    // Everything observable, packed: hex(56) ledr(18) ledg(9) line0(48)
    // line1(48) uart(1).
    logic [179:0] obs_all;
    assign obs_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0,
                      ledr, ledg,
                      d0x0, d0x1, d0x2, d0x3, d0x4, d0x5,
                      d1x0, d1x1, d1x2, d1x3, d1x4, d1x5,
                      uart_txd};

    // Glyph artwork, segments a..g left to right, 0 = lit.
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    string hex_chars = "0123456789ABCDEF";

    function automatic logic [27:0] word_glyphs(input logic [15:0] v);
        logic [27:0] r;
        for (int i = 0; i < 4; i++)
            r[27 - 7*i -: 7] = glyph[v[15 - 4*i -: 4]];
        return r;
    endfunction

    function automatic logic [47:0] word_line(input logic [15:0] v);
        logic [47:0] r;
        r[47:32] = {"0", "x"};
        for (int i = 0; i < 4; i++)
            r[31 - 8*i -: 8] = hex_chars[v[15 - 4*i -: 4]];
        return r;
    endfunction

    function automatic logic [179:0] model_all(input logic [17:0] s,
                                               input logic [15:0] c,
                                               input int n);
        logic [7:0] n8;
        n8 = n[7:0];
        return {word_glyphs(s[15:0]), word_glyphs(c),
                s, (c == s[15:0]), n8,
                word_line(s[15:0]), word_line(c), 1'b1};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // Press KEY[1] with word v; the model loads at the second edge after
    // the first edge that sees the key low.
    task automatic press(input logic [15:0] v);
        sw[15:0] = v;
        key1 = 1'b0;
        step(3);
        m_cap = v;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic release_key();
        key1 = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw = 18'h0FACA;
        key1 = 1'b1;
        m_cap = 16'h0000;
        m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #50 key1 = ~key1;
            #1;
            total++;
            if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs_all,
                         model_all(sw, m_cap, m_cnt));
            end
        end
        sw = 18'h3FACA;
        #1;
        total++;
        if (ledr !== 18'h3FACA) begin
            bad++;
            $display("FAIL reset_ledr_upper: got %h want %h", ledr, 18'h3FACA);
        end
    endtask

    task automatic test_first_load();
        key1 = 1'b1;
        sw = 18'h0AAAA;
        step(1);
        rst_n = 1'b1;
        step(1);
        key1 = 1'b0;
        step(2);
        total++;
        if (ledg[7:0] !== 8'd0 || hex3 !== glyph[0]) begin
            bad++;
            $display("FAIL first_load_early: got ledg=%h hex3=%b want ledg=00 hex3=%b",
                     ledg, hex3, glyph[0]);
        end
        step(1);
        m_cap = 16'hAAAA;
        m_cnt = 1;
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL first_load: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
    endtask

    task automatic test_hold_no_reload();
        sw = 18'h0BBBB;
        step(6);
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL hold_no_reload: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        total++;
        if (ledg[8] !== 1'b0) begin
            bad++;
            $display("FAIL hold_match: got %b want 0", ledg[8]);
        end
        release_key();
    endtask

    task automatic test_random_loads();
        logic [15:0] v;
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom);
            press(v);
            total++;
            if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
                bad++;
                $display("FAIL rand_load[%0d]: got %h want %h", i, obs_all,
                         model_all(sw, m_cap, m_cnt));
            end
            sw = 18'($urandom);
            step(2);
            total++;
            if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
                bad++;
                $display("FAIL rand_held[%0d]: got %h want %h", i, obs_all,
                         model_all(sw, m_cap, m_cnt));
            end
            release_key();
        end
    endtask

    task automatic test_wrap();
        while (m_cnt != 255) begin
            press(16'($urandom));
            release_key();
        end
        total++;
        if (ledg[7:0] !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_pre: got %h want ff", ledg[7:0]);
        end
        press(16'h1234);
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL wrap: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        release_key();
    endtask

    task automatic test_reset_midpress();
        press(16'hCCCC);
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL midpress_load: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        #3 rst_n = 1'b0;
        #1;
        m_cap = 16'h0000;
        m_cnt = 0;
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL midpress_async_reset: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        step(2);
        rst_n = 1'b1;
        step(2);
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL post_reset_early: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        step(1);
        m_cap = sw[15:0];
        m_cnt = 1;
        step(4);
        total++;
        if (obs_all !== model_all(sw, m_cap, m_cnt)) begin
            bad++;
            $display("FAIL post_reset_held_load: got %h want %h", obs_all,
                     model_all(sw, m_cap, m_cnt));
        end
        release_key();
    endtask

    initial begin
        uart_rxd = 1'b1;
        test_reset();
        test_first_load();
        test_hold_no_reload();
        test_random_loads();
        test_wrap();
        test_reset_midpress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
